// File: rtl/ring_readout_ctrl.sv
// Ring readout controller: serialises ring words onto one valid/ready stream.
// Define RING_READOUT_HDR_EN to emit a {ring,replica} header before each replica.
module ring_readout_ctrl #(
    parameter int RING_NUM    = 2,
    parameter int REPLICA_NUM = 32,
    parameter int WORD_NUM    = 8,
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [RING_NUM-1:0]        ring_valid,
    input  logic [RING_NUM*DATA_W-1:0] ring_data,
    output logic [RING_NUM-1:0]        ring_shift,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int WW = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam int PW = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1;
    localparam int RW = (RING_NUM > 1) ? $clog2(RING_NUM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [WW-1:0] WLAST = WW'(WORD_NUM - 1);
    localparam logic [PW-1:0] PLAST = PW'(REPLICA_NUM - 1);
    localparam logic [RW-1:0] RLAST = RW'(RING_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        DRAIN,
        DONE
`ifdef RING_READOUT_HDR_EN
        , HDR
`endif
    } state_t;

    state_t state, state_nx;

    logic [WW-1:0] word_cnt;
    logic [PW-1:0] rep_cnt;
    logic [RW-1:0] ring_cnt;

    logic [DATA_W-1:0] mem      [FIFO_DEPTH];
    logic              last_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] head_data;
    logic              head_last;

    logic              fifo_full, fifo_empty, pop;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              last_word;
    logic              take, push, push_last, advance, flush;
    logic [DATA_W-1:0] push_data;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign out_valid  = !fifo_empty;
    assign out_data   = head_data;
    assign out_last   = out_valid && head_last;
    assign pop        = out_valid && out_ready;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    assign last_word = (ring_cnt == RLAST) && (rep_cnt == PLAST)
                    && (word_cnt == WLAST);

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int r = 0; r < RING_NUM; r++) begin
            if (ring_cnt == RW'(r)) begin
                sel_valid = ring_valid[r];
                sel_data  = ring_data[r*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        take      = 1'b0;
        push      = 1'b0;
        push_data = sel_data;
        push_last = 1'b0;
        advance   = 1'b0;
        flush     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
`ifdef RING_READOUT_HDR_EN
                    state_nx = HDR;
`else
                    state_nx = XFER;
`endif
                end
            end
`ifdef RING_READOUT_HDR_EN
            HDR: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = DATA_W'({ring_cnt, rep_cnt});
                    state_nx  = XFER;
                end
            end
`endif
            XFER: begin
                take      = sel_valid && !fifo_full;
                push      = take;
                advance   = take;
                push_last = take && last_word;
                if (take && last_word) begin
                    state_nx = DRAIN;
                end
`ifdef RING_READOUT_HDR_EN
                else if (take && word_cnt == WLAST) begin
                    state_nx = HDR;
                end
`endif
            end
            DRAIN: begin
                if (fifo_empty || (pop && count == CW'(1))) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // abort wins over everything; nothing leaves the rings that cycle
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            take     = 1'b0;
            push     = 1'b0;
            advance  = 1'b0;
            flush    = 1'b1;
        end
    end

    always_comb begin
        ring_shift = '0;
        for (int r = 0; r < RING_NUM; r++) begin
            ring_shift[r] = take && (ring_cnt == RW'(r));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
            rep_cnt  <= '0;
            ring_cnt <= '0;
        end else if (flush) begin
            word_cnt <= '0;
            rep_cnt  <= '0;
            ring_cnt <= '0;
        end else if (advance) begin
            if (word_cnt == WLAST) begin
                word_cnt <= '0;
                if (rep_cnt == PLAST) begin
                    rep_cnt  <= '0;
                    ring_cnt <= (ring_cnt == RLAST) ? '0 : ring_cnt + RW'(1);
                end else begin
                    rep_cnt <= rep_cnt + PW'(1);
                end
            end else begin
                word_cnt <= word_cnt + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]      <= push_data;
            last_mem[wr_ptr] <= push_last;
        end
    end

    // head is a registered copy of the oldest entry so it holds when empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
            head_last <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (push && (fifo_empty || (pop && count == CW'(1)))) begin
                head_data <= push_data;
                head_last <= push_last;
            end else if (pop && count > CW'(1)) begin
                head_data <= mem[rd_ptr + AW'(1)];
                head_last <= last_mem[rd_ptr + AW'(1)];
            end
        end
    end

endmodule

// File: tb/tb_ring_readout_ctrl.sv
// Bench for ring_readout_ctrl: control table, ring model and output scoreboard.
// Covers RING_READOUT_HDR_EN builds with a 1x2x2 configuration.
module tb_ring_readout_ctrl;

`ifdef RING_READOUT_HDR_EN
    localparam int RN = 1;
    localparam int PN = 2;
    localparam int WN = 2;
    localparam int HW = 1;
`else
    localparam int RN = 2;
    localparam int PN = 32;
    localparam int WN = 8;
    localparam int HW = 0;
`endif
    localparam int DW       = 64;
    localparam int FD       = 4;
    localparam int TOTAL    = RN * PN * (WN + HW);
    localparam int PW       = (PN > 1) ? $clog2(PN) : 1;
    localparam int ABORT_AT = (TOTAL > 200) ? 97 : 1;
    localparam int RST_AT   = (TOTAL > 200) ? 50 : 2;

    logic               clk;
    logic               reset;
    logic               start;
    logic               abort;
    logic [RN-1:0]      ring_valid;
    logic [RN*DW-1:0]   ring_data;
    logic [RN-1:0]      ring_shift;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               done;

    ring_readout_ctrl #(
        .RING_NUM(RN), .REPLICA_NUM(PN), .WORD_NUM(WN),
        .DATA_W(DW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .ring_valid(ring_valid), .ring_data(ring_data),
        .ring_shift(ring_shift), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        bit st;
        bit ab;
        bit bsy;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   words_popped = 0;
    int   ring_idx[RN];
    bit   occ_en = 0;
    int   occ = 0;
    int   occ_max = 0;
    int   rdy_mode = 0;
    int   last_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] enc(int r, int p, int w);
        return (64'(1) << 48) | (64'(r) << 32) | (64'(p) << 16) | 64'(w);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_rings();
        for (int r = 0; r < RN; r++)
            ring_data[r*DW +: DW] = enc(r, ring_idx[r] / WN, ring_idx[r] % WN);
    endtask

    task automatic reseed();
        for (int r = 0; r < RN; r++) ring_idx[r] = 0;
        drive_rings();
    endtask

    task automatic build_expected();
        q.delete();
        words_popped = 0;
        for (int r = 0; r < RN; r++) begin
            for (int p = 0; p < PN; p++) begin
`ifdef RING_READOUT_HDR_EN
                q.push_back('{data: DW'((r << PW) | p), last: 1'b0});
`endif
                for (int w = 0; w < WN; w++)
                    q.push_back('{data: enc(r, p, w),
                                  last: (r == RN-1 && p == PN-1 && w == WN-1)});
            end
        end
    endtask

    // ring model: a word is consumed on the edge after ring_shift is seen
    initial begin
        logic [RN-1:0] sh;
        forever begin
            @(negedge clk);
            sh = ring_shift;
            @(posedge clk);
            #1;
            for (int r = 0; r < RN; r++) if (sh[r]) ring_idx[r]++;
            drive_rings();
        end
    end

    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                out_ready = (c % 4 == 0);
                c++;
            end
        end
    end

    // output scoreboard and FIFO occupancy model
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (occ_en) begin
                if (occ == FD) check("shift_at_full", 64'(ring_shift), 0);
                occ = occ + int'(|ring_shift) - int'(out_valid && out_ready);
                if (occ > occ_max) occ_max = occ;
            end
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_word: got %0h expected none", out_data);
                end else begin
                    e = q.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_last", 64'(out_last), 64'(e.last));
                    words_popped++;
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_rise", 64'(busy), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int cyc = 0;
        bit got = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
        end
        last_cyc = cyc;
        check({tag, "_done_seen"}, 64'(got), 1);
        check({tag, "_busy_at_done"}, 64'(busy), 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 0);
        check({tag, "_idle_after"}, 64'(busy), 0);
        check({tag, "_word_count"}, 64'(words_popped), 64'(TOTAL));
        check({tag, "_queue_empty"}, 64'(q.size()), 0);
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (words_popped < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reached"}, 64'(words_popped >= n), 1);
    endtask

    initial begin
        vec_t tbl[9];
        tbl[0] = '{st: 0, ab: 0, bsy: 0};
        tbl[1] = '{st: 1, ab: 0, bsy: 1};
        tbl[2] = '{st: 0, ab: 0, bsy: 1};
        tbl[3] = '{st: 1, ab: 0, bsy: 1};
        tbl[4] = '{st: 0, ab: 1, bsy: 0};
        tbl[5] = '{st: 0, ab: 0, bsy: 0};
        tbl[6] = '{st: 1, ab: 1, bsy: 0};
        tbl[7] = '{st: 1, ab: 0, bsy: 1};
        tbl[8] = '{st: 0, ab: 1, bsy: 0};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ring_valid = '0;
        out_ready = 1'b0;
        reseed();
        #2;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_last", 64'(out_last), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_shift", 64'(ring_shift), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // control table with rings silent and consumer stalled
        for (int i = 0; i < 9; i++) begin
            start = tbl[i].st;
            abort = tbl[i].ab;
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
            check($sformatf("tbl%0d_done", i), 64'(done), 0);
            check($sformatf("tbl%0d_shift", i), 64'(ring_shift), 0);
        end

        // full readout at one word per cycle
        reseed();
        build_expected();
        ring_valid = '1;
        out_ready = 1'b1;
        pulse_start();
        wait_done("full", TOTAL + 50);
        check("throughput", 64'(last_cyc <= TOTAL + 3), 1);

        // consumer accepts one cycle in four
        reseed();
        build_expected();
        occ = 0;
        occ_max = 0;
`ifndef RING_READOUT_HDR_EN
        occ_en = 1;
`endif
        rdy_mode = 1;
        pulse_start();
        wait_done("bp", TOTAL * 4 + 50);
        rdy_mode = 0;
        occ_en = 0;
        out_ready = 1'b1;
`ifndef RING_READOUT_HDR_EN
        check("fifo_filled", 64'(occ_max), 64'(FD));

        // ring 1 silent for 20 cycles once ring 0 is exhausted
        @(posedge clk);
        #1;
        reseed();
        build_expected();
        ring_valid = RN'(1);
        pulse_start();
        wait_words("stall", PN * WN, TOTAL * 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_shift", i), 64'(ring_shift), 0);
            check($sformatf("stall%0d_busy", i), 64'(busy), 1);
        end
        @(posedge clk);
        #1;
        ring_valid = '1;
        wait_done("stall", TOTAL + 50);
`endif

        // abort with words sitting in the FIFO
        @(posedge clk);
        #1;
        reseed();
        build_expected();
        ring_valid = '1;
        out_ready = 1'b1;
        pulse_start();
        wait_words("abort", ABORT_AT, TOTAL * 2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_abort_valid", 64'(out_valid), 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_shift", 64'(ring_shift), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("abort_no_done%0d", i), 64'(done), 0);
        end
        @(posedge clk);
        #1;
        reseed();
        build_expected();
        out_ready = 1'b1;
        pulse_start();
        wait_done("restart", TOTAL + 50);

        // asynchronous reset mid-transfer, then start spam while busy
        @(posedge clk);
        #1;
        reseed();
        build_expected();
        pulse_start();
        repeat (RST_AT) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 0);
        check("arst_busy", 64'(busy), 0);
        check("arst_shift", 64'(ring_shift), 0);
        check("arst_done", 64'(done), 0);
        check("arst_last", 64'(out_last), 0);
        check("arst_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reseed();
        build_expected();
        pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("spam", TOTAL + 50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_readout_ctrl.md
Name: ring_readout_ctrl

Overview:
- Serialises replica ordering data from RING_NUM replica rings onto one valid/ready stream toward the bus interface.
- Generalised successor of the two-ring (or/tw) read bank selection: ring count, words per replica, replica count and data width are all parametrised.
- Adds a ring-side handshake, an output FIFO and an explicit readout state machine with done/abort.
- Sits between the node rings and the bus readout register.

Parameters:
- RING_NUM, 2, number of replica rings read in order 0..RING_NUM-1.
- REPLICA_NUM, 32, replicas per ring (node_num).
- WORD_NUM, 8, data words per replica (city_div).
- DATA_W, 64, word width.
- FIFO_DEPTH, 4, output buffer depth; power of two, >=2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  pulse; begin full readout
- abort  in  1  pulse; stop readout, flush FIFO
- ring_valid  in  RING_NUM  ring r presents a word
- ring_data  in  RING_NUM*DATA_W  word from ring r; ring r occupies bits [r*DATA_W +: DATA_W]
- ring_shift  out  RING_NUM  ring r word accepted; ring advances
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_W  FIFO head word
- out_last  out  1  head is final word of the readout
- out_ready  in  1  consumer accepts head
- busy  out  1  readout in progress, including drain
- done  out  1  one-cycle pulse when the last word leaves the FIFO

Behaviour:
- Reset is asynchronous, active-high. On reset: state IDLE, all counters 0, FIFO empty. Outputs: ring_shift=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- Counters:
  - word_cnt: $clog2(WORD_NUM), minimum 1 bit.
  - rep_cnt: $clog2(REPLICA_NUM), minimum 1 bit.
  - ring_cnt: $clog2(RING_NUM), minimum 1 bit.
  - Ordering is word fastest, then replica, then ring.
- States: IDLE, XFER, DRAIN, DONE.
  - IDLE -> XFER on start. busy rises the next cycle.
  - XFER: ring_shift[ring_cnt] = ring_valid[ring_cnt] && !fifo_full. All other ring_shift bits are 0.
  - XFER: on each accepted word, push ring_data[ring_cnt] into the FIFO and advance the counters with wrap. The final word (ring RING_NUM-1, replica REPLICA_NUM-1, word WORD_NUM-1) is pushed with the last flag set, and the state moves to DRAIN.
  - DRAIN -> DONE when the FIFO becomes empty.
  - DONE: done=1 for exactly one cycle, then IDLE.
- FIFO:
  - Registered head. A push into an empty FIFO gives out_valid=1 the next cycle, so minimum latency is 1 cycle from ring_shift to out_valid.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop while full is allowed only if the pop frees the slot; fifo_full is evaluated before the pop (conservative), so no push at full.
  - When empty, out_data holds its last value and out_valid=0.
  - Sustained throughput is 1 word/cycle when out_ready=1 and ring_valid=1.
- start while busy=1 is ignored.
- abort, any state except IDLE:
  - Next cycle: state IDLE, FIFO flushed (out_valid=0), counters 0, ring_shift=0, no done pulse.
  - abort has priority over start in the same cycle.
  - Words already shifted from the rings are lost; re-seeding the rings is the caller's responsibility.
- out_last is high only while the final word is at the FIFO head.
- Degenerate parameters: RING_NUM=1, REPLICA_NUM=1 and WORD_NUM=1 must all work; a 1x1x1 readout is 1 word with out_last=1.

Optional Feature:
- Macro: RING_READOUT_HDR_EN.
- Defined:
  - Before the first word of each replica, one header word is pushed from an extra HDR state: {ring_cnt, rep_cnt} right-aligned, zero-extended to DATA_W.
  - HDR pushes whenever !fifo_full; no ring_shift is asserted that cycle.
  - Total words pushed = RING_NUM*REPLICA_NUM*(WORD_NUM+1).
- Undefined: no HDR state; total words = RING_NUM*REPLICA_NUM*WORD_NUM.

Test Plan:
- Defaults, rings always valid, ring_data = {ring,rep,word} encoding, out_ready=1, start -> 512 words in order ring0 rep0 w0..ring1 rep31 w7. out_last only on the 512th word, done pulses once, and busy spans start+1 to done.
- out_ready toggled 1-of-4 cycles -> FIFO fills to 4, ring_shift=0 while full, no word lost or duplicated, and order is preserved.
- ring_valid[1] held low for 20 cycles when ring_cnt=1 -> no shift on either ring and the state stays XFER. The sequence resumes unchanged when ring_valid[1] rises.
- abort at word 100 with FIFO holding 3 words -> next cycle out_valid=0, busy=0, no done. A following start reads from ring0 rep0 w0 again.
- Reset asserted mid-XFER (asynchronously, between clock edges) -> outputs clear immediately. start during busy has no effect; the count remains 512.
- RING_READOUT_HDR_EN with RING_NUM=1, REPLICA_NUM=2, WORD_NUM=2 -> stream is hdr(0,0), w0, w1, hdr(0,1), w0, w1, with out_last on the 6th word.
